// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// default bit timing, parity mode constants and the parity check helper.
package uart_rx_cfg_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // 10 MHz clock, 38400 baud
  localparam int unsigned DEFAULT_CLK_DIV = 260;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Data is zero-extended to 8 bits; the extra zeros do not change the XOR.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic       par_bit,
                                        input logic       odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous output FIFO for received words. The head is visible
// combinationally; while empty the head output holds the last popped word.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty_s, full_s, do_push_s, do_pop_s;

  // Flags, accepted push/pop and next pointers; full+pop still accepts a push
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_pop_s  = pop_i & ~empty_s;
    do_push_s = push_i & (~full_s | do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      last_d   = mem_q[rd_ptr_q[PTR_W-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
    end
    if (empty_s) begin
      head_o = last_q;
    end else begin
      head_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign drop_o  = push_i & full_s & ~do_pop_s;
  assign count_o = wr_ptr_q - rd_ptr_q;

  // Pointer and held-head registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchroniser, half-bit start
// validation, DATA_W data bits LSB first, optional parity, 1/2 checked stop
// bits, and an output FIFO with a valid/ready pop interface.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic                          rx_busy,
  output logic                          rx_valid,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned WORD_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV);
  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              push_q, push_d;
  logic [WORD_W-1:0] push_word_q, push_word_d;
  logic              overrun_q, overrun_d;
  logic              rx_s, fall_s, tick_s;
  logic              fifo_empty_s, fifo_full_s, fifo_drop_s;
  logic [WORD_W-1:0] head_s;

  assign rx_s   = sync2_q;
  assign fall_s = prev_q & ~sync2_q;
  assign tick_s = (cnt_q == CNT_W'(1));

  // Line synchroniser plus edge-detect history, preset to idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM and datapath state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: bit timing, sampling, error capture and push request
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    if (tick_s) begin
      cnt_d = CNT_FULL;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      ST_START: begin
        if (tick_s && !rx_s) begin
          state_d = ST_DATA;
          bit_d   = 4'd0;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else if (tick_s) begin
          state_d = ST_IDLE;   // line went back high: glitch
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = 4'd0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          perr_d  = parity_error(8'(shift_q), rx_s, ODD_MODE);
          bit_d   = 4'd0;
          state_d = ST_STOP;
        end else begin
          perr_d  = perr_q;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          ferr_d = ferr_q | ~rx_s;
          if (bit_q == LAST_STOP) begin
            push_d      = 1'b1;
            push_word_d = {ferr_q | ~rx_s, perr_q, shift_q};
            bit_d       = 4'd0;
            // A low final stop bit means a break: wait for the line to recover
            state_d     = rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            bit_d       = bit_q + 4'd1;
          end
        end else begin
          ferr_d = ferr_q;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky overrun: a new drop wins over a simultaneous clear
  always_comb begin
    if (fifo_drop_s) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_q),
    .push_data_i (push_word_q),
    .pop_i       (rx_ready),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .drop_o      (fifo_drop_s),
    .count_o     (fifo_count)
  );

  assign rx_busy  = (state_q != ST_IDLE);
  assign rx_valid = ~fifo_empty_s;
  assign rx_data  = head_s[DATA_W-1:0];
  assign rx_perr  = head_s[DATA_W];
  assign rx_ferr  = head_s[DATA_W+1];
  assign overrun  = overrun_q;

  logic unused_s;
  assign unused_s = fifo_full_s;

endmodule
